// File: rtl/gcd_operand_demux.sv
// gcd_operand_demux: loads operand pairs A/B from one valid/ready bus and launches the GCD controller
// Ports: clk, rst_n (sync, active low); in_data/in_valid/in_ready operand input bus;
//        a_out/b_out registered operands; load_sel 0=A next, 1=B next; start launch pulse;
//        busy high from start until done_in; done_in controller finished; zero_err rejected pair pulse;
//        pair_count number of launched pairs (wraps).
module gcd_operand_demux #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             load_sel,
  output logic             start,
  output logic             busy,
  input  logic             done_in,
  output logic             zero_err,
  output logic [CNT_W-1:0] pair_count
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, CHECK, RUN} state_t;
  state_t state, state_nx;
  logic xfer, zero;
  always_comb begin
    in_ready = (state == LOAD_A) || (state == LOAD_B);
    load_sel = state == LOAD_B;
    xfer     = in_valid && in_ready;
    zero     = (a_out == '0) || (b_out == '0);
    start    = (state == CHECK) && !zero;
    zero_err = (state == CHECK) && zero;
    busy     = (state == RUN) || start;
    state_nx = state;
    case (state)
      LOAD_A: state_nx = xfer ? LOAD_B : LOAD_A;
      LOAD_B: state_nx = xfer ? CHECK : LOAD_B;
      CHECK:  state_nx = zero ? LOAD_A : RUN;
      RUN:    state_nx = done_in ? LOAD_A : RUN;
      default: state_nx = LOAD_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      a_out      <= '0;
      b_out      <= '0;
      pair_count <= '0;
    end else begin
      state <= state_nx;
      if (xfer && !load_sel) a_out <= in_data;
      if (xfer && load_sel) b_out <= in_data;
      if (start) pair_count <= pair_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gcd_operand_demux.sv
// tb_gcd_operand_demux: directed self-checking bench for gcd_operand_demux
module tb_gcd_operand_demux;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] in_data = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] a_out, b_out;
  logic        load_sel, start, busy, done_in = 0, zero_err;
  logic [7:0]  pair_count;
  int checks = 0, failures = 0;

  gcd_operand_demux #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_out(a_out), .b_out(b_out), .load_sel(load_sel), .start(start), .busy(busy),
    .done_in(done_in), .zero_err(zero_err), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    in_data = a; in_valid = 1;
    @(negedge clk);
    in_data = b;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_cnt", pair_count, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_sel", load_sel, 0);
    chk("rst_zerr", zero_err, 0);
    rst_n = 1;

    in_data = 36; in_valid = 1;
    @(negedge clk);
    chk("t2_a", a_out, 36);
    chk("t2_sel_b", load_sel, 1);
    in_data = 24;
    @(negedge clk);
    chk("t2_b", b_out, 24);
    chk("t2_start", start, 1);
    chk("t2_busy_chk", busy, 1);
    chk("t2_rdy_chk", in_ready, 0);
    in_data = 99;
    @(negedge clk);
    chk("t2_start_off", start, 0);
    chk("t2_busy_run", busy, 1);
    chk("t2_cnt", pair_count, 1);
    repeat (3) @(negedge clk);
    chk("t3_rdy_run", in_ready, 0);
    chk("t3_a_hold", a_out, 36);
    done_in = 1;
    @(negedge clk);
    done_in = 0;
    chk("t3_busy_off", busy, 0);
    chk("t3_rdy", in_ready, 1);
    chk("t3_a_wait", a_out, 36);
    @(negedge clk);
    chk("t3_a99", a_out, 99);
    chk("t3_sel", load_sel, 1);
    in_data = 0;
    @(negedge clk);
    in_valid = 0;
    chk("t3_zerr_b0", zero_err, 1);
    chk("t3_nostart", start, 0);
    @(negedge clk);
    chk("t3_zerr_off", zero_err, 0);

    send_pair(0, 5);
    chk("t4_zerr", zero_err, 1);
    chk("t4_start", start, 0);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_zerr_pulse", zero_err, 0);
    chk("t4_cnt", pair_count, 1);
    chk("t4_rdy", in_ready, 1);
    chk("t4_sel", load_sel, 0);

    send_pair(7, 3);
    chk("t5_start", start, 1);
    done_in = 1;
    @(negedge clk);
    done_in = 0;
    chk("t5_done_ign", busy, 1);
    chk("t5_cnt", pair_count, 2);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t5_busy", busy, 0);
    chk("t5_a", a_out, 0);
    chk("t5_b", b_out, 0);
    chk("t5_cnt_rst", pair_count, 0);
    chk("t5_rdy", in_ready, 1);
    done_in = 1;
    @(negedge clk);
    done_in = 0;
    chk("t5_sel_after", load_sel, 0);
    in_data = 11; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("t5_a11", a_out, 11);
    chk("t5_b_keep", b_out, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 256; i++) begin
      send_pair(16'(i + 1), 2);
      @(negedge clk);
      done_in = 1;
      @(negedge clk);
      done_in = 0;
      if (i == 254) chk("t6_cnt255", pair_count, 255);
      if (i == 255) chk("t6_wrap", pair_count, 0);
    end
    chk("t6_a_last", a_out, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
